// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus types: bus commands, tag-ownership entries and sizing constants.
package mem_bus_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int MEM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  // owner: 0 = D-cache (port 0), 1 = I-cache (port 1)
  typedef struct packed {
    logic valid;
    logic owner;
  } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Tag ownership table: one allocate port, one lookup/clear port; allocation
// overrides a same-cycle clear of the same tag.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAGS = MEM_TAGS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  logic [3:0] alloc_tag,
  input  logic       alloc_owner,
  input  logic [3:0] lookup_tag,
  output logic       lookup_valid,
  output logic       lookup_owner
);

  localparam logic [3:0] TAG_MAX = 4'(TAGS);

  MEM_OWNER_ENTRY table_r [0:TAGS];
  MEM_OWNER_ENTRY lookup_entry_s;
  logic           alloc_ok_s;

  // Lookup reads registered state only; tag 0 and out-of-range tags never hit.
  always_comb begin
    lookup_entry_s = '0;
    if ((lookup_tag != 4'd0) && (lookup_tag <= TAG_MAX)) begin
      lookup_entry_s = table_r[lookup_tag];
    end else begin
      lookup_entry_s = '0;
    end
  end

  assign alloc_ok_s   = alloc_en && (alloc_tag != 4'd0) && (alloc_tag <= TAG_MAX);
  assign lookup_valid = lookup_entry_s.valid;
  assign lookup_owner = lookup_entry_s.owner;

  // Clear on a routed return, then allocate; the later write wins on a shared tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= TAGS; i++) begin
        table_r[i] <= '0;
      end
    end else begin
      if (lookup_entry_s.valid) begin
        table_r[lookup_tag].valid <= 1'b0;
      end
      if (alloc_ok_s) begin
        table_r[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory bus between the D-cache (port 0) and I-cache (port 1),
// with starvation protection for the I-cache and tag-routed data returns.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TAGS         = MEM_TAGS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      dc_cmd,
  input  logic [XLEN-1:0] dc_addr,
  input  logic [63:0]     dc_data,
  output logic            dc_ack,
  output logic            dc_ret_valid,
  output logic [63:0]     dc_ret_data,
  input  logic [1:0]      ic_cmd,
  input  logic [XLEN-1:0] ic_addr,
  output logic            ic_ack,
  output logic            ic_ret_valid,
  output logic [63:0]     ic_ret_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [3:0]      ack_tag,
  output logic            orphan_err
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_r;
  logic          orphan_err_r;
  logic          dc_req_s;
  logic          ic_req_s;
  logic          sel_dc_s;
  logic          sel_ic_s;
  logic          accepted_s;
  logic          dc_ack_s;
  logic          ic_ack_s;
  logic          alloc_en_s;
  logic          hit_s;
  logic          hit_owner_s;

  assign dc_req_s   = (dc_cmd == BUS_LOAD) || (dc_cmd == BUS_STORE);
  assign ic_req_s   = (ic_cmd == BUS_LOAD);
  assign sel_ic_s   = ic_req_s && (!dc_req_s || (starve_cnt_r == LIMIT));
  assign sel_dc_s   = dc_req_s && !sel_ic_s;
  assign accepted_s = (mem2proc_response != 4'd0);
  assign dc_ack_s   = sel_dc_s && accepted_s;
  assign ic_ack_s   = sel_ic_s && accepted_s;
  assign alloc_en_s = (dc_ack_s && (dc_cmd == BUS_LOAD)) || ic_ack_s;

  // Forward the chosen request to memory; the I-cache never carries store data.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = 64'd0;
    if (sel_ic_s) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ic_addr;
      proc2mem_data    = 64'd0;
    end else if (sel_dc_s) begin
      proc2mem_command = dc_cmd;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_data;
    end else begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = 64'd0;
    end
  end

  mem_tag_table #(
    .TAGS (TAGS)
  ) u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en_s),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (ic_ack_s),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (hit_s),
    .lookup_owner (hit_owner_s)
  );

  assign dc_ack       = dc_ack_s;
  assign ic_ack       = ic_ack_s;
  assign ack_tag      = (dc_ack_s || ic_ack_s) ? mem2proc_response : 4'd0;
  assign dc_ret_valid = hit_s && !hit_owner_s;
  assign ic_ret_valid = hit_s && hit_owner_s;
  assign dc_ret_data  = mem2proc_data;
  assign ic_ret_data  = mem2proc_data;
  assign orphan_err   = orphan_err_r;

  // Starvation counter: saturates while port 1 waits, and the saturated value
  // holds through a memory refusal so port 1 keeps priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (ic_req_s && !ic_ack_s) begin
      if (starve_cnt_r != LIMIT) begin
        starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= '0;
    end
  end

  // Sticky flag for returns whose tag has no recorded owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      orphan_err_r <= 1'b0;
    end else if ((mem2proc_tag != 4'd0) && !hit_s) begin
      orphan_err_r <= 1'b1;
    end else begin
      orphan_err_r <= orphan_err_r;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      dc_cmd, ic_cmd;
  logic [XLEN-1:0] dc_addr, ic_addr;
  logic [63:0]     dc_data;
  logic            dc_ack, dc_ret_valid, ic_ack, ic_ret_valid;
  logic [63:0]     dc_ret_data, ic_ret_data;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response, mem2proc_tag, ack_tag;
  logic [63:0]     mem2proc_data;
  logic            orphan_err;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_data(dc_data), .dc_ack(dc_ack),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .ic_cmd(ic_cmd), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .ack_tag(ack_tag), .orphan_err(orphan_err)
  );

  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dc_cmd = BUS_NONE; dc_addr = '0; dc_data = 64'd0;
    ic_cmd = BUS_NONE; ic_addr = '0;
    mem2proc_response = 4'd0; mem2proc_data = 64'd0; mem2proc_tag = 4'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    mem2proc_tag = 4'd1;
    tick();
    tick();
    #1;
    total++; if (dc_ret_valid !== 1'b0 || ic_ret_valid !== 1'b0) begin bad++; $display("FAIL reset_ret: dc=%0b ic=%0b want 0 0", dc_ret_valid, ic_ret_valid); end
    total++; if (orphan_err !== 1'b0) begin bad++; $display("FAIL reset_orphan: got %0b want 0", orphan_err); end
    total++; if (proc2mem_command !== 2'h0 || proc2mem_addr !== 32'h0 || proc2mem_data !== 64'h0) begin bad++; $display("FAIL reset_bus: cmd=%0h addr=%0h data=%0h want 0 0 0", proc2mem_command, proc2mem_addr, proc2mem_data); end
    total++; if (dc_ack !== 1'b0 || ic_ack !== 1'b0 || ack_tag !== 4'd0) begin bad++; $display("FAIL reset_ack: dc=%0b ic=%0b tag=%0d want 0 0 0", dc_ack, ic_ack, ack_tag); end
    mem2proc_tag = 4'd0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_dc_only();
    dc_cmd = BUS_LOAD; dc_addr = 32'h100; mem2proc_response = 4'd3;
    #1;
    total++; if (dc_ack !== 1'b1 || ic_ack !== 1'b0 || ack_tag !== 4'd3) begin bad++; $display("FAIL dc_only_ack: dc=%0b ic=%0b tag=%0d want 1 0 3", dc_ack, ic_ack, ack_tag); end
    total++; if (proc2mem_command !== 2'h1 || proc2mem_addr !== 32'h100) begin bad++; $display("FAIL dc_only_bus: cmd=%0h addr=%0h want 1 100", proc2mem_command, proc2mem_addr); end
    tick();
    idle();
    tick(); tick(); tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
    #1;
    total++; if (dc_ret_valid !== 1'b1 || ic_ret_valid !== 1'b0 || dc_ret_data !== 64'hDEAD) begin bad++; $display("FAIL dc_only_ret: dc=%0b ic=%0b data=%0h want 1 0 dead", dc_ret_valid, ic_ret_valid, dc_ret_data); end
    tick();
    idle();
    #1;
    total++; if (orphan_err !== 1'b0) begin bad++; $display("FAIL dc_only_orphan: got %0b want 0", orphan_err); end
  endtask

  task automatic test_contention();
    // per cycle: memory response, expected dc_ack, expected ic_ack
    logic [3:0] resp  [11] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    logic       exp_d [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_i [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    dc_cmd = BUS_LOAD; dc_addr = 32'hD00;
    ic_cmd = BUS_LOAD; ic_addr = 32'hC00;
    for (int i = 0; i < 11; i++) begin
      mem2proc_response = resp[i];
      #1;
      total++; if (dc_ack !== exp_d[i] || ic_ack !== exp_i[i]) begin bad++; $display("FAIL contention_cyc%0d: dc=%0b ic=%0b want %0b %0b", i, dc_ack, ic_ack, exp_d[i], exp_i[i]); end
      if (i == 9) begin
        total++; if (proc2mem_addr !== 32'hC00) begin bad++; $display("FAIL starve_refused_sel: addr=%0h want c00", proc2mem_addr); end
      end
      tick();
    end
    mem2proc_response = 4'd1;
    #1;
    total++; if (dc_ack !== 1'b1) begin bad++; $display("FAIL starve_cleared: dc_ack=%0b want 1", dc_ack); end
    idle();
  endtask

  task automatic test_refusal();
    do_reset();
    ic_cmd = BUS_LOAD; ic_addr = 32'h200;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (ic_ack !== 1'b0 || ack_tag !== 4'd0 || proc2mem_command !== 2'h1 || proc2mem_addr !== 32'h200) begin bad++; $display("FAIL refusal_hold%0d: ack=%0b tag=%0d cmd=%0h addr=%0h want 0 0 1 200", i, ic_ack, ack_tag, proc2mem_command, proc2mem_addr); end
      tick();
    end
    mem2proc_response = 4'd7;
    #1;
    total++; if (ic_ack !== 1'b1 || ack_tag !== 4'd7) begin bad++; $display("FAIL refusal_ack: ack=%0b tag=%0d want 1 7", ic_ack, ack_tag); end
    tick();
    idle();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
    #1;
    total++; if (ic_ret_valid !== 1'b1 || dc_ret_valid !== 1'b0 || ic_ret_data !== 64'h77) begin bad++; $display("FAIL refusal_owner: ic=%0b dc=%0b data=%0h want 1 0 77", ic_ret_valid, dc_ret_valid, ic_ret_data); end
    tick();
    idle();
  endtask

  task automatic test_store();
    do_reset();
    dc_cmd = BUS_STORE; dc_addr = 32'h300; dc_data = 64'h1234; mem2proc_response = 4'd2;
    #1;
    total++; if (dc_ack !== 1'b1 || ack_tag !== 4'd2 || proc2mem_command !== 2'h2 || proc2mem_data !== 64'h1234) begin bad++; $display("FAIL store_ack: ack=%0b tag=%0d cmd=%0h data=%0h want 1 2 2 1234", dc_ack, ack_tag, proc2mem_command, proc2mem_data); end
    tick();
    idle();
    mem2proc_tag = 4'd2;
    #1;
    total++; if (dc_ret_valid !== 1'b0 || ic_ret_valid !== 1'b0) begin bad++; $display("FAIL store_noalloc: dc=%0b ic=%0b want 0 0", dc_ret_valid, ic_ret_valid); end
    tick();
    idle();
    #1;
    total++; if (orphan_err !== 1'b1) begin bad++; $display("FAIL store_orphan: got %0b want 1", orphan_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ic_cmd = BUS_LOAD; ic_addr = 32'h500; mem2proc_response = 4'd5;
    tick();
    idle();
    dc_cmd = BUS_LOAD; dc_addr = 32'h600; mem2proc_response = 4'd5;
    mem2proc_tag = 4'd5; mem2proc_data = 64'hAAAA;
    #1;
    total++; if (ic_ret_valid !== 1'b1 || dc_ret_valid !== 1'b0 || dc_ack !== 1'b1) begin bad++; $display("FAIL reuse_old_owner: ic=%0b dc=%0b ack=%0b want 1 0 1", ic_ret_valid, dc_ret_valid, dc_ack); end
    tick();
    idle();
    mem2proc_tag = 4'd5; mem2proc_data = 64'hBBBB;
    #1;
    total++; if (dc_ret_valid !== 1'b1 || ic_ret_valid !== 1'b0 || dc_ret_data !== 64'hBBBB) begin bad++; $display("FAIL reuse_new_owner: dc=%0b ic=%0b data=%0h want 1 0 bbbb", dc_ret_valid, ic_ret_valid, dc_ret_data); end
    tick();
    idle();
    #1;
    total++; if (orphan_err !== 1'b0) begin bad++; $display("FAIL reuse_orphan: got %0b want 0", orphan_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dc_cmd = BUS_LOAD; dc_addr = 32'h40; mem2proc_response = 4'd4;
    tick();
    idle();
    ic_cmd = BUS_LOAD; ic_addr = 32'h80; mem2proc_response = 4'd6;
    tick();
    do_reset();
    mem2proc_tag = 4'd4;
    #1;
    total++; if (dc_ret_valid !== 1'b0 || ic_ret_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_ret4: dc=%0b ic=%0b want 0 0", dc_ret_valid, ic_ret_valid); end
    tick();
    mem2proc_tag = 4'd6;
    #1;
    total++; if (dc_ret_valid !== 1'b0 || ic_ret_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_ret6: dc=%0b ic=%0b want 0 0", dc_ret_valid, ic_ret_valid); end
    tick();
    idle();
    #1;
    total++; if (orphan_err !== 1'b1) begin bad++; $display("FAIL mid_reset_orphan: got %0b want 1", orphan_err); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_dc_only();
    test_contention();
    test_refusal();
    test_store();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
